// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared lc3b types, including the L1 cache controller state encoding
package lc3b_types;

    typedef logic [8:0] lc3b_tag;
    typedef logic [2:0] lc3b_index;
    typedef logic [1:0] lc3b_mem_wmask;

    typedef enum logic [1:0] {
        S_HIT       = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } lc3b_cache_state;

endpackage

// File: rtl/cache_lru_array.sv
// rtl/cache_lru_array.sv - per-set 1-bit LRU flops, one write port and one combinational read port
module cache_lru_array #(
    parameter int NUM_SETS = 8,
    parameter int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] index,
    input  logic             we,
    input  logic             din,
    output logic             dout
);

    logic [NUM_SETS-1:0] lru;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru <= '0;
        end else if (we) begin
            lru[index] <= din;
        end
    end

    assign dout = lru[index];

endmodule

// File: rtl/cache_control.sv
// rtl/cache_control.sv - control FSM for the 2-way write-back, write-allocate L1 cache
module cache_control
    import lc3b_types::*;
#(
    parameter int NUM_SETS = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [15:0]      mem_address,
    input  logic             hit0,
    input  logic             hit1,
    input  logic             dirty0,
    input  logic             dirty1,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic             way_sel,
    output logic             load_data,
    output logic             data_in_sel,
    output logic             load_tag,
    output logic             set_valid,
    output logic             set_dirty,
    output logic             clr_dirty,
    output logic             lru_way,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W = $clog2(NUM_SETS);

    lc3b_cache_state  state, next_state;
    logic [IDX_W-1:0] index;
    logic             req, is_write, hit, victim_dirty;
    logic             lru_we, lru_din, miss_inc;
    logic             addr_unused;

    assign index        = mem_address[IDX_W+3:4];
    assign addr_unused  = ^{mem_address[15:IDX_W+4], mem_address[3:0]};
    assign req          = mem_read | mem_write;
    // Simultaneous read and write resolves to a read.
    assign is_write     = mem_write & ~mem_read;
    assign hit          = hit0 | hit1;
    assign victim_dirty = lru_way ? dirty1 : dirty0;

    cache_lru_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (IDX_W)
    ) u_lru (
        .clk   (clk),
        .rst_n (rst_n),
        .index (index),
        .we    (lru_we),
        .din   (lru_din),
        .dout  (lru_way)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_HIT;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_count <= '0;
        end else if (miss_inc && (miss_count != {CNT_W{1'b1}})) begin
            miss_count <= miss_count + CNT_W'(1);
        end
    end

    always_comb begin
        next_state    = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        way_sel       = 1'b0;
        load_data     = 1'b0;
        data_in_sel   = 1'b0;
        load_tag      = 1'b0;
        set_valid     = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        lru_we        = 1'b0;
        lru_din       = 1'b0;
        miss_inc      = 1'b0;

        case (state)
            S_HIT: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // A double hit is treated as a way0 hit.
                        way_sel  = hit1 & ~hit0;
                        if (is_write) begin
                            load_data   = 1'b1;
                            data_in_sel = 1'b1;
                            set_dirty   = 1'b1;
                        end
                        lru_we  = 1'b1;
                        lru_din = ~(hit1 & ~hit0);
                    end else begin
                        miss_inc   = 1'b1;
                        next_state = victim_dirty ? S_WRITEBACK : S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                way_sel       = lru_way;
                if (pmem_resp) begin
                    next_state = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                pmem_read = 1'b1;
                way_sel   = lru_way;
                if (pmem_resp) begin
                    load_data  = 1'b1;
                    load_tag   = 1'b1;
                    set_valid  = 1'b1;
                    clr_dirty  = 1'b1;
                    next_state = S_HIT;
                end
            end
            default: begin
                next_state = S_HIT;
            end
        endcase
    end

    a_dual_hit: assert property (@(posedge clk) disable iff (!rst_n)
        !((state == S_HIT) && req && hit0 && hit1));

    a_read_write: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_read && mem_write));

endmodule

// File: tb/tb_cache_control.sv
// tb/tb_cache_control.sv - directed vector bench for cache_control
module tb_cache_control;

    localparam logic [10:0] O_MRESP = 11'b100_0000_0000;
    localparam logic [10:0] O_PRD   = 11'b010_0000_0000;
    localparam logic [10:0] O_PWR   = 11'b001_0000_0000;
    localparam logic [10:0] O_PASEL = 11'b000_1000_0000;
    localparam logic [10:0] O_WAY   = 11'b000_0100_0000;
    localparam logic [10:0] O_LDATA = 11'b000_0010_0000;
    localparam logic [10:0] O_DSEL  = 11'b000_0001_0000;
    localparam logic [10:0] O_LTAG  = 11'b000_0000_1000;
    localparam logic [10:0] O_SVAL  = 11'b000_0000_0100;
    localparam logic [10:0] O_SDRT  = 11'b000_0000_0010;
    localparam logic [10:0] O_CDRT  = 11'b000_0000_0001;
    localparam logic [10:0] O_FILL  = O_PRD | O_LDATA | O_LTAG | O_SVAL | O_CDRT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [15:0] mem_address;
    logic        hit0, hit1, dirty0, dirty1, pmem_resp;

    logic        mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel;
    logic        load_data, data_in_sel, load_tag, set_valid, set_dirty, clr_dirty;
    logic        lru_way;
    logic [15:0] miss_count;

    logic        mem_resp2, pmem_read2, pmem_write2, pmem_addr_sel2, way_sel2;
    logic        load_data2, data_in_sel2, load_tag2, set_valid2, set_dirty2, clr_dirty2;
    logic        lru_way2;
    logic [1:0]  miss_count2;

    logic [10:0] outs, outs2;
    assign outs  = {mem_resp, pmem_read, pmem_write, pmem_addr_sel, way_sel, load_data,
                    data_in_sel, load_tag, set_valid, set_dirty, clr_dirty};
    assign outs2 = {mem_resp2, pmem_read2, pmem_write2, pmem_addr_sel2, way_sel2, load_data2,
                    data_in_sel2, load_tag2, set_valid2, set_dirty2, clr_dirty2};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_control dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .hit0(hit0), .hit1(hit1), .dirty0(dirty0),
        .dirty1(dirty1), .pmem_resp(pmem_resp), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_addr_sel(pmem_addr_sel), .way_sel(way_sel),
        .load_data(load_data), .data_in_sel(data_in_sel), .load_tag(load_tag),
        .set_valid(set_valid), .set_dirty(set_dirty), .clr_dirty(clr_dirty),
        .lru_way(lru_way), .miss_count(miss_count)
    );

    cache_control #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .hit0(hit0), .hit1(hit1), .dirty0(dirty0),
        .dirty1(dirty1), .pmem_resp(pmem_resp), .mem_resp(mem_resp2), .pmem_read(pmem_read2),
        .pmem_write(pmem_write2), .pmem_addr_sel(pmem_addr_sel2), .way_sel(way_sel2),
        .load_data(load_data2), .data_in_sel(data_in_sel2), .load_tag(load_tag2),
        .set_valid(set_valid2), .set_dirty(set_dirty2), .clr_dirty(clr_dirty2),
        .lru_way(lru_way2), .miss_count(miss_count2)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic        h0;
        logic        h1;
        logic        presp;
        logic [10:0] exp_outs;
        logic        exp_lru;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
        dirty0    = 1'b0;
        dirty1    = 1'b0;
        pmem_resp = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 16'h0124, 1'b0, 1'b1, 1'b0,
                    O_MRESP | O_WAY | O_LDATA | O_DSEL | O_SDRT, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h0124, 1'b1, 1'b0, 1'b0, O_MRESP, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 16'h0070, 1'b0, 1'b1, 1'b0, O_MRESP | O_WAY, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 16'h0070, 1'b1, 1'b0, 1'b0,
                    O_MRESP | O_LDATA | O_DSEL | O_SDRT, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b1, O_MRESP, 1'b1};

        rst_n       = 1'b0;
        mem_address = 16'h0000;
        idle_inputs();
        #2;
        chk("reset_outs", 32'(outs), 32'd0);
        chk("reset_lru", 32'(lru_way), 32'd0);
        chk("reset_miss_count", 32'(miss_count), 32'd0);
        step();
        rst_n = 1'b1;

        // Clean read miss on index 4, filled into way0.
        mem_read    = 1'b1;
        mem_address = 16'h0040;
        #1;
        chk("miss_cycle_outs", 32'(outs), 32'd0);
        step();
        chk("alloc_outs", 32'(outs), 32'(O_PRD));
        chk("miss_count_1", 32'(miss_count), 32'd1);
        step();
        chk("alloc_hold_outs", 32'(outs), 32'(O_PRD));
        pmem_resp = 1'b1;
        #1;
        chk("alloc_resp_outs", 32'(outs), 32'(O_FILL));
        step();
        pmem_resp = 1'b0;
        hit0      = 1'b1;
        #1;
        chk("post_fill_hit", 32'(outs), 32'(O_MRESP));
        step();
        idle_inputs();
        #1;
        chk("lru_idx4", 32'(lru_way), 32'd1);
        chk("idle_outs", 32'(outs), 32'd0);

        for (int i = 0; i < 6; i++) begin
            mem_read    = vecs[i].rd;
            mem_write   = vecs[i].wr;
            mem_address = vecs[i].addr;
            hit0        = vecs[i].h0;
            hit1        = vecs[i].h1;
            pmem_resp   = vecs[i].presp;
            #1;
            chk($sformatf("vec%0d_outs", i), 32'(outs), 32'(vecs[i].exp_outs));
            step();
            idle_inputs();
            #1;
            chk($sformatf("vec%0d_lru", i), 32'(lru_way), 32'(vecs[i].exp_lru));
        end

        // Dirty victim (way1) on index 2: writeback then fill.
        mem_read    = 1'b1;
        mem_address = 16'h0120;
        dirty1      = 1'b1;
        #1;
        chk("wb_lru_victim", 32'(lru_way), 32'd1);
        step();
        for (int c = 1; c <= 5; c++) begin
            if (c == 5) pmem_resp = 1'b1;
            #1;
            chk($sformatf("wb_cycle%0d", c), 32'(outs), 32'(O_PWR | O_PASEL | O_WAY));
            step();
        end
        pmem_resp = 1'b0;
        dirty1    = 1'b0;
        #1;
        chk("wb_alloc_outs", 32'(outs), 32'(O_PRD | O_WAY));
        chk("miss_count_2", 32'(miss_count), 32'd2);
        step();
        pmem_resp = 1'b1;
        #1;
        chk("wb_alloc_resp", 32'(outs), 32'(O_FILL | O_WAY));
        step();
        pmem_resp = 1'b0;
        hit1      = 1'b1;
        #1;
        chk("wb_hit", 32'(outs), 32'(O_MRESP | O_WAY));
        step();
        idle_inputs();
        #1;
        chk("wb_lru_idx2", 32'(lru_way), 32'd0);

        // Reset asserted on the third allocate cycle.
        mem_read    = 1'b1;
        mem_address = 16'h0050;
        step();
        step();
        step();
        chk("rst_alloc_cycle3", 32'(outs), 32'(O_PRD));
        rst_n = 1'b0;
        #1;
        chk("rst_pmem_read_drop", 32'(pmem_read), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        mem_read = 1'b0;
        for (int s = 0; s < 8; s++) begin
            mem_address = 16'(s << 4);
            #1;
            chk($sformatf("rst_lru_idx%0d", s), 32'(lru_way), 32'd0);
        end
        step();
        rst_n = 1'b1;

        // Request dropped mid-fill: fill completes, no mem_resp.
        mem_read    = 1'b1;
        mem_address = 16'h0030;
        step();
        mem_read = 1'b0;
        #1;
        chk("drop_alloc_outs", 32'(outs), 32'(O_PRD));
        pmem_resp = 1'b1;
        #1;
        chk("drop_alloc_resp", 32'(outs), 32'(O_FILL));
        step();
        pmem_resp = 1'b0;
        #1;
        chk("drop_back_idle", 32'(outs), 32'd0);
        mem_read = 1'b1;
        hit0     = 1'b1;
        #1;
        chk("drop_then_hit", 32'(outs), 32'(O_MRESP));
        step();
        idle_inputs();

        // Saturation of a 2-bit counter over five clean misses.
        rst_n = 1'b0;
        step();
        rst_n       = 1'b1;
        mem_read    = 1'b1;
        mem_address = 16'h0000;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("sat_cnt2_miss%0d", k), 32'(miss_count2), (k > 3) ? 32'd3 : 32'(k));
            chk($sformatf("sat_cnt16_miss%0d", k), 32'(miss_count), 32'(k));
            chk($sformatf("sat_outs_match%0d", k), 32'(outs2), 32'(O_PRD));
            pmem_resp = 1'b1;
            step();
            pmem_resp = 1'b0;
        end
        idle_inputs();
        #1;
        chk("sat_final_lru2", 32'(lru_way2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
